// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 master.
package spi_pkg;

   localparam int unsigned DEF_CLK_DIV = 2;
   localparam int unsigned DEF_DATA_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      WAIT_NEXT,
      HOLD,
      GAP
   } spi_state_e;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: reloads to CLK_DIV-1 on state entry, flags phase end at zero.
module spi_half_tick
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   output logic phase_end
);

   localparam int unsigned      CNT_W = cnt_width(CLK_DIV);
   localparam logic [CNT_W-1:0] LOAD  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Reload on request, otherwise count down and park at zero.
   always_comb begin
      cnt_nxt = cnt;
      if (reload) begin
         cnt_nxt = LOAD;
      end else if (cnt != '0) begin
         cnt_nxt = cnt - CNT_W'(1);
      end
   end

   // Counter and registered zero flag, so phase_end tracks the live count value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= LOAD;
         phase_end <= (LOAD == '0);
      end else begin
         cnt       <= cnt_nxt;
         phase_end <= (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, byte chaining within one ce0 window.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   output logic              tx_ready,
   input  logic              end_xfer,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              ce0
);

   localparam int unsigned     BC_W   = cnt_width(DATA_W);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(DATA_W - 1);

   spi_state_e        state;
   spi_state_e        state_nxt;

   logic              phase_end;
   logic              reload;
   logic              accept;

   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] tx_sh_nxt;
   logic [DATA_W-1:0] rx_sh;
   logic [DATA_W-1:0] rx_sh_nxt;
   logic [BC_W-1:0]   bit_cnt;
   logic [BC_W-1:0]   bit_cnt_nxt;
   logic              last_q;
   logic              last_nxt;

   logic              ce0_nxt;
   logic              sclk_nxt;
   logic              mosi_nxt;
   logic [DATA_W-1:0] rx_data_nxt;
   logic              rx_valid_nxt;
   logic              tx_ready_nxt;
   logic              busy_nxt;

   assign accept = tx_valid && tx_ready;
   assign reload = (state_nxt != state);

   spi_half_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_half_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .reload    (reload),
      .phase_end (phase_end)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-value logic for the shifter and all registered outputs.
   always_comb begin
      state_nxt    = state;
      ce0_nxt      = ce0;
      sclk_nxt     = sclk;
      mosi_nxt     = mosi;
      tx_sh_nxt    = tx_sh;
      rx_sh_nxt    = rx_sh;
      bit_cnt_nxt  = bit_cnt;
      last_nxt     = last_q;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               tx_sh_nxt   = tx_data;
               mosi_nxt    = tx_data[DATA_W-1];
               last_nxt    = tx_last;
               bit_cnt_nxt = BC_MAX;
               ce0_nxt     = 1'b0;
               state_nxt   = SETUP;
            end
         end
         SETUP, LOW: begin
            // Rising sclk edge: sample miso on the same clk edge.
            if (phase_end) begin
               sclk_nxt  = 1'b1;
               rx_sh_nxt = {rx_sh[DATA_W-2:0], miso};
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (phase_end) begin
               sclk_nxt = 1'b0;
               if (bit_cnt != '0) begin
                  // Rotate keeps every shifter bit live; mosi takes the next bit down.
                  bit_cnt_nxt = bit_cnt - BC_W'(1);
                  tx_sh_nxt   = {tx_sh[DATA_W-2:0], tx_sh[DATA_W-1]};
                  mosi_nxt    = tx_sh[DATA_W-2];
                  state_nxt   = LOW;
               end else begin
                  rx_data_nxt  = rx_sh;
                  rx_valid_nxt = 1'b1;
                  state_nxt    = last_q ? HOLD : WAIT_NEXT;
               end
            end
         end
         WAIT_NEXT: begin
            // A new byte takes priority over an end-of-transfer request.
            if (accept) begin
               tx_sh_nxt   = tx_data;
               mosi_nxt    = tx_data[DATA_W-1];
               last_nxt    = tx_last;
               bit_cnt_nxt = BC_MAX;
               state_nxt   = SETUP;
            end else if (end_xfer) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (phase_end) begin
               ce0_nxt   = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (phase_end) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            ce0_nxt   = 1'b1;
            sclk_nxt  = 1'b0;
         end
      endcase

      tx_ready_nxt = (state_nxt == IDLE) || (state_nxt == WAIT_NEXT);
      busy_nxt     = (state_nxt != IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sh    <= '0;
         rx_sh    <= '0;
         bit_cnt  <= '0;
         last_q   <= 1'b0;
         ce0      <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         tx_sh    <= tx_sh_nxt;
         rx_sh    <= rx_sh_nxt;
         bit_cnt  <= bit_cnt_nxt;
         last_q   <= last_nxt;
         ce0      <= ce0_nxt;
         sclk     <= sclk_nxt;
         mosi     <= mosi_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         tx_ready <= tx_ready_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: CLK_DIV=2 and CLK_DIV=1 instances, behavioural slave.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n;
   int         sel;
   logic [7:0] tx_data;
   logic       tx_valid, tx_last, end_xfer, miso;

   logic       tx_ready0, rx_valid0, busy0, sclk0, mosi0, ce00;
   logic       tx_ready1, rx_valid1, busy1, sclk1, mosi1, ce01;
   logic [7:0] rx_data0, rx_data1;

   logic       tx_ready_m, rx_valid_m, busy_m, sclk_m, mosi_m, ce0_m;
   logic [7:0] rx_data_m;
   logic       tx_valid0, tx_valid1, end_xfer0, end_xfer1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign tx_valid0  = tx_valid && (sel == 0);
   assign tx_valid1  = tx_valid && (sel == 1);
   assign end_xfer0  = end_xfer && (sel == 0);
   assign end_xfer1  = end_xfer && (sel == 1);
   assign tx_ready_m = (sel == 1) ? tx_ready1 : tx_ready0;
   assign rx_valid_m = (sel == 1) ? rx_valid1 : rx_valid0;
   assign rx_data_m  = (sel == 1) ? rx_data1  : rx_data0;
   assign busy_m     = (sel == 1) ? busy1     : busy0;
   assign sclk_m     = (sel == 1) ? sclk1     : sclk0;
   assign mosi_m     = (sel == 1) ? mosi1     : mosi0;
   assign ce0_m      = (sel == 1) ? ce01      : ce00;

   spi_master #(.CLK_DIV(2), .DATA_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid0), .tx_last(tx_last),
      .tx_ready(tx_ready0), .end_xfer(end_xfer0), .rx_data(rx_data0), .rx_valid(rx_valid0),
      .busy(busy0), .sclk(sclk0), .mosi(mosi0), .miso(miso), .ce0(ce00)
   );

   spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid1), .tx_last(tx_last),
      .tx_ready(tx_ready1), .end_xfer(end_xfer1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .busy(busy1), .sclk(sclk1), .mosi(mosi1), .miso(miso), .ce0(ce01)
   );

   // Behavioural mode-0 slave: response byte k is rsp_q[k], mosi captured on sclk rise.
   logic [7:0] rsp_q[$];
   logic [7:0] cap_got[$];
   int         byte_idx = 0;
   int         s_bits   = 0;
   logic [7:0] s_cap    = 8'h00;

   function automatic logic cur_bit();
      logic [7:0] r;
      r = (byte_idx < rsp_q.size()) ? rsp_q[byte_idx] : 8'h00;
      return r[3'(7 - s_bits)];
   endfunction

   initial miso = 1'b0;

   always @(negedge ce0_m) begin
      s_bits = 0;
      s_cap  = 8'h00;
      miso   = cur_bit();
   end

   always @(posedge sclk_m) begin
      if (!ce0_m) begin
         s_cap = {s_cap[6:0], mosi_m};
         s_bits++;
         if (s_bits == 8) begin
            cap_got.push_back(s_cap);
            s_bits = 0;
            byte_idx++;
         end
      end
   end

   always @(negedge sclk_m) begin
      if (!ce0_m) miso = cur_bit();
   end

   // Protocol monitor sampled on the inactive clock edge.
   int         cyc = 0, low_cnt = 0, last_low = 0, frames = 0, rises = 0, pulses = 0;
   int         sclk_bad = 0, mosi_bad = 0, t_rise = 0, t_busy_fall = 0, t_sr = 0;
   int         min_gap = 1000, min_rint = 1000;
   bit         seen_rise = 1'b0, seen_sr = 1'b0;
   logic       ce0_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0, busy_p = 1'b0;
   logic [7:0] rx_got[$];

   always @(negedge clk) begin
      cyc++;
      if (!ce0_m) low_cnt++;
      if (ce0_m && !ce0_p) begin
         last_low  = low_cnt;
         low_cnt   = 0;
         frames++;
         t_rise    = cyc;
         seen_rise = 1'b1;
      end
      if (!ce0_m && ce0_p && seen_rise && (cyc - t_rise < min_gap)) min_gap = cyc - t_rise;
      if (sclk_m && !sclk_p) begin
         rises++;
         if (seen_sr && (cyc - t_sr < min_rint)) min_rint = cyc - t_sr;
         t_sr    = cyc;
         seen_sr = 1'b1;
      end
      if (sclk_m && ce0_m) sclk_bad++;
      if (sclk_m && sclk_p && (mosi_m != mosi_p)) mosi_bad++;
      if (rx_valid_m) begin
         pulses++;
         rx_got.push_back(rx_data_m);
      end
      if (!busy_m && busy_p) t_busy_fall = cyc;
      ce0_p  = ce0_m;
      sclk_p = sclk_m;
      mosi_p = mosi_m;
      busy_p = busy_m;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic int q_at(input logic [7:0] q[$], input int i);
      return (i < q.size()) ? int'(q[i]) : -1;
   endfunction

   task automatic clear_mon(input int s);
      @(posedge clk);
      #1;
      sel = s;
      #1;
      ce0_p = ce0_m; sclk_p = sclk_m; mosi_p = mosi_m; busy_p = busy_m;
      low_cnt = 0; last_low = 0; frames = 0; rises = 0; pulses = 0;
      sclk_bad = 0; mosi_bad = 0; t_rise = 0; t_busy_fall = 0;
      min_gap = 1000; min_rint = 1000; seen_rise = 1'b0; seen_sr = 1'b0;
      rx_got.delete(); cap_got.delete(); rsp_q.delete();
      byte_idx = 0; s_bits = 0;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic last);
      int n = 0;
      @(negedge clk);
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      while (!tx_ready_m && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         chk("ready_timeout", 0, 1);
         tx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      tx_last  = 1'($urandom);
   endtask

   task automatic wait_ready();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_ready_m && n < 2000);
      if (n >= 2000) chk("wait_ready_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy_m && n < 5000);
      if (n >= 5000) chk("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int sel;
      int tx;
      int rsp;
      int low;
      int lag;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int gapbad;
      int div;
      logic [7:0] txb[$];
      logic       lastb[$];

      tbl[0] = '{0, 'hA5, 'h3C, 34, 2};
      tbl[1] = '{0, 'h00, 'hFF, 34, 2};
      tbl[2] = '{0, 'h81, 'h7E, 34, 2};
      tbl[3] = '{1, 'h3C, 'hA5, 17, 1};
      tbl[4] = '{1, 'hA5, 'h3C, 17, 1};
      tbl[5] = '{1, 'hFF, 'h01, 17, 1};

      sel = 0; rst_n = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; end_xfer = 1'b0; tx_data = 8'h00;
      #2 rst_n = 1'b0;
      #2;
      chk("rst_ce0", int'(ce0_m), 1);
      chk("rst_sclk", int'(sclk_m), 0);
      chk("rst_mosi", int'(mosi_m), 0);
      chk("rst_rx_data", int'(rx_data_m), 0);
      chk("rst_rx_valid", int'(rx_valid_m), 0);
      chk("rst_tx_ready", int'(tx_ready_m), 1);
      chk("rst_busy", int'(busy_m), 0);
      chk("rst_ce0_div1", int'(ce01), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single-byte frames with loopback responses on both clock divisors.
      for (int i = 0; i < 6; i++) begin
         clear_mon(tbl[i].sel);
         rsp_q.push_back(8'(tbl[i].rsp));
         push_byte(8'(tbl[i].tx), 1'b1);
         wait_idle();
         chk("tbl_ce0_low_len", last_low, tbl[i].low);
         chk("tbl_sclk_rises", rises, 8);
         chk("tbl_mosi_byte", q_at(cap_got, 0), tbl[i].tx);
         chk("tbl_rx_pulses", pulses, 1);
         chk("tbl_rx_data", q_at(rx_got, 0), tbl[i].rsp);
         chk("tbl_busy_lag", t_busy_fall - t_rise, tbl[i].lag);
         chk("tbl_sclk_high_ce0_high", sclk_bad, 0);
         chk("tbl_mosi_change_sclk_high", mosi_bad, 0);
      end

      // Chained bytes with a 5-cycle wait between them.
      clear_mon(0);
      rsp_q.push_back(8'h11);
      rsp_q.push_back(8'h22);
      push_byte(8'h01, 1'b0);
      wait_ready();
      gapbad = 0;
      repeat (5) begin
         @(negedge clk);
         if (sclk_m || ce0_m) gapbad++;
      end
      push_byte(8'h80, 1'b1);
      wait_idle();
      chk("chain_wait_sclk_ce0", gapbad, 0);
      chk("chain_frames", frames, 1);
      chk("chain_rises", rises, 16);
      chk("chain_pulses", pulses, 2);
      chk("chain_rx0", q_at(rx_got, 0), 'h11);
      chk("chain_rx1", q_at(rx_got, 1), 'h22);
      chk("chain_mosi0", q_at(cap_got, 0), 'h01);
      chk("chain_mosi1", q_at(cap_got, 1), 'h80);

      // Early release via end_xfer while waiting for a chained byte.
      clear_mon(0);
      rsp_q.push_back(8'h5C);
      push_byte(8'hFF, 1'b0);
      wait_ready();
      end_xfer = 1'b1;
      @(posedge clk);
      #1 end_xfer = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (ce0_m) break;
         n++;
      end
      chk("early_ce0_lag", n, 2);
      wait_idle();
      chk("early_tx_ready", int'(tx_ready_m), 1);
      chk("early_pulses", pulses, 1);
      chk("early_rx", q_at(rx_got, 0), 'h5C);
      chk("early_mosi", q_at(cap_got, 0), 'hFF);

      // tx_valid and end_xfer together in WAIT_NEXT: the byte wins.
      clear_mon(0);
      rsp_q.push_back(8'h33);
      rsp_q.push_back(8'h44);
      push_byte(8'h12, 1'b0);
      wait_ready();
      tx_data = 8'h34; tx_last = 1'b1; tx_valid = 1'b1; end_xfer = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0; end_xfer = 1'b0; tx_data = 8'hEE; tx_last = 1'b0;
      @(negedge clk);
      chk("simul_ce0_low", int'(ce0_m), 0);
      chk("simul_tx_ready", int'(tx_ready_m), 0);
      wait_idle();
      chk("simul_frames", frames, 1);
      chk("simul_pulses", pulses, 2);
      chk("simul_mosi1", q_at(cap_got, 1), 'h34);
      chk("simul_rx1", q_at(rx_got, 1), 'h44);

      // Asynchronous reset in the middle of a byte.
      clear_mon(0);
      rsp_q.push_back(8'h77);
      push_byte(8'hFF, 1'b1);
      n = 0;
      while (rises < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ce0", int'(ce0_m), 1);
      chk("mid_rst_sclk", int'(sclk_m), 0);
      chk("mid_rst_mosi", int'(mosi_m), 0);
      chk("mid_rst_busy", int'(busy_m), 0);
      chk("mid_rst_tx_ready", int'(tx_ready_m), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_no_rx_valid", pulses, 0);
      chk("mid_rst_rx_data", int'(rx_data_m), 0);
      clear_mon(0);
      rsp_q.push_back(8'h96);
      push_byte(8'h5A, 1'b1);
      wait_idle();
      chk("post_rst_mosi", q_at(cap_got, 0), 'h5A);
      chk("post_rst_rx", q_at(rx_got, 0), 'h96);
      chk("post_rst_low_len", last_low, 34);

      // Randomized back-to-back multi-byte frames against the slave/reference queues.
      for (int s = 0; s < 2; s++) begin
         div = (s == 0) ? 2 : 1;
         clear_mon(s);
         txb.delete();
         lastb.delete();
         for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 3));
            for (int b = 0; b < n; b++) begin
               txb.push_back(8'($urandom));
               lastb.push_back(b == n - 1);
               rsp_q.push_back(8'($urandom));
            end
         end
         for (int i = 0; i < txb.size(); i++) begin
            if (i != 0 && !lastb[i-1]) repeat ($urandom_range(0, 3)) @(negedge clk);
            push_byte(txb[i], lastb[i]);
         end
         wait_idle();
         chk("rnd_mosi_count", cap_got.size(), txb.size());
         chk("rnd_rx_count", rx_got.size(), txb.size());
         for (int i = 0; i < txb.size(); i++) begin
            chk("rnd_mosi_byte", q_at(cap_got, i), int'(txb[i]));
            chk("rnd_rx_byte", q_at(rx_got, i), int'(rsp_q[i]));
         end
         chk("rnd_frames", frames, 6);
         chk("rnd_rises", rises, 8 * txb.size());
         chk("rnd_min_ce0_gap_ok", int'(min_gap >= div), 1);
         chk("rnd_sclk_period", min_rint, 2 * div);
         chk("rnd_sclk_high_ce0_high", sclk_bad, 0);
         chk("rnd_mosi_change_sclk_high", mosi_bad, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte-granular SPI mode-0 master (CPOL=0, CPHA=0), MSB first. Drives the icestick SPI slave from the FPGA side, or drives external SPI peripherals.
- Accepts bytes over a valid/ready handshake and serialises each one on mosi/sclk with ce0 held low.
- Returns the byte captured on miso each transfer.
- Bytes can be chained inside one chip-select window.

Parameters:
- CLK_DIV, 2, clk cycles per sclk half-period; legal range ≥1.
- DATA_W, 8, bits per transfer.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_W  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  sampled with tx_data; 1 = release ce0 after this byte.
- tx_ready  out  1  master can accept a byte this cycle.
- end_xfer  in  1  release ce0 while waiting for a chained byte.
- rx_data  out  DATA_W  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high whenever state ≠ IDLE.
- sclk  out  1  SPI clock.
- mosi  out  1  master out.
- miso  in  1  master in; treated as synchronous to our own sclk, no synchroniser.
- ce0  out  1  active-low chip select.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE, ce0=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0.
- Reset asserted mid-transfer aborts at once. No partial rx_valid is produced.
- Accept condition: tx_valid && tx_ready. tx_ready=1 only in IDLE and WAIT_NEXT.
- A half-period counter reloads to CLK_DIV-1 on every state entry. "Phase end" means the counter equals 0.
- States:
  - IDLE: on accept, load tx shift register and last flag, set bit_cnt=DATA_W-1. Next cycle ce0=0 and mosi=tx_data[MSB]. Go to SETUP.
  - SETUP: ce0 low, sclk 0. At phase end: sclk←1, sample miso into rx shift LSB, go to HIGH.
  - HIGH: at phase end, sclk←0, then:
    - bit_cnt≠0: decrement bit_cnt, mosi←next bit, go to LOW.
    - bit_cnt=0: rx_data←assembled byte, rx_valid=1 for exactly one cycle. Go to HOLD if last, else WAIT_NEXT.
  - LOW: at phase end, sclk←1, sample miso, go to HIGH.
  - WAIT_NEXT: ce0 stays low, sclk=0.
    - On accept: load next byte, mosi=MSB, go to SETUP.
    - Else if end_xfer: go to HOLD.
    - tx_valid and end_xfer asserted in the same cycle: accept wins.
  - HOLD: ce0 low, sclk 0, CLK_DIV cycles. Then ce0←1, go to GAP.
  - GAP: ce0 high, CLK_DIV cycles. Then go to IDLE. Guarantees minimum ce0-high time between transfers.
- Edge timing:
  - mosi changes only while sclk=0, i.e. on the falling-edge transition or before the first rising edge.
  - miso is sampled on the same clk edge that drives sclk 0→1.
- Single-byte frame length: ce0 low for exactly CLK_DIV×(2×DATA_W+1) cycles; 34 at defaults. sclk shows exactly DATA_W rising edges.
- tx_data and tx_last are ignored when tx_ready=0. The value captured at accept is used, even if inputs change later.
- sclk idles low; it is never high outside HIGH.

Decomposition:
- spi_pkg holds:
  - state enum (IDLE, SETUP, HIGH, LOW, WAIT_NEXT, HOLD, GAP);
  - default CLK_DIV and DATA_W constants.
- One sub-module: spi_half_tick.
  - Loadable down-counter, width derived from CLK_DIV.
  - Provides reload on state entry and phase_end output.
- The FSM and shift registers stay in spi_master.

Test Plan:
- Single byte, CLK_DIV=2: tx_data=0xA5, tx_last=1; slave model returns 0x3C.
  - mosi sampled at sclk rising edges = 1,0,1,0,0,1,0,1.
  - rx_data=0x3C, one rx_valid pulse.
  - ce0 low exactly 34 clk; busy drops 2 clk after ce0 rises.
- Chained: 0x01 (tx_last=0) then 0x80 (tx_last=1) presented 5 cycles later.
  - ce0 stays low throughout; 16 sclk rises.
  - Two rx_valid pulses; sclk low during the WAIT_NEXT gap.
- Early release: 0xFF with tx_last=0, then end_xfer pulse, no tx_valid.
  - ce0 rises CLK_DIV cycles after end_xfer is seen; returns to IDLE with tx_ready=1.
- Simultaneous tx_valid and end_xfer in WAIT_NEXT: byte is accepted and ce0 stays low.
- Reset mid-byte: assert rst_n=0 after the 3rd sclk rise.
  - ce0=1, sclk=0, mosi=0 immediately, with no clk edge needed; no rx_valid.
  - The next transfer of 0x5A completes correctly.
- CLK_DIV=1 with back-to-back frames: sclk period is 2 clk and the 0x3C/0xA5 loopback still matches.
  - GAP gives ≥1 clk of ce0 high between frames.
